// File: rtl/fsm_frame_tx.sv
// fsm_frame_tx: serial frame transmitter, header 1-0-1 then payload MSB first then IDLE_GAP zero bits.
// Define FSM_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module fsm_frame_tx #(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              Dout,
  output logic              busy,
  output logic              frame_done
);
`ifdef FSM_FRAME_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int MAXV = DATA_W > IDLE_GAP ? DATA_W : IDLE_GAP;
  localparam int CW   = $clog2(MAXV + 1);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA, PAR, GAP} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] sr_q;
  logic [CW-1:0]     cnt_q;
  logic              par_q, dout_q, ready_q, busy_q, done_q;
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && ready_q) begin
            state_q <= HDR0;
            sr_q    <= in_data;
            par_q   <= ^in_data;
            dout_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            dout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        HDR0: begin
          state_q <= HDR1;
          dout_q  <= 1'b0;
        end
        HDR1: begin
          state_q <= HDR2;
          dout_q  <= 1'b1;
        end
        HDR2: begin
          state_q <= DATA;
          dout_q  <= sr_q[DATA_W-1];
          sr_q    <= sr_q << 1;
          cnt_q   <= CW'(DATA_W - 1);
          done_q  <= !PAR_EN && DATA_W == 1;
        end
        DATA, PAR: begin
          // cnt_q holds the payload bits still to be shifted out
          if (state_q == DATA && cnt_q != '0) begin
            dout_q <= sr_q[DATA_W-1];
            sr_q   <= sr_q << 1;
            cnt_q  <= cnt_q - CW'(1);
            done_q <= !PAR_EN && cnt_q == CW'(1);
          end else if (state_q == DATA && PAR_EN) begin
            state_q <= PAR;
            dout_q  <= par_q;
            done_q  <= 1'b1;
          end else if (IDLE_GAP == 0) begin
            state_q <= IDLE;
            dout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= GAP;
            dout_q  <= 1'b0;
            cnt_q   <= CW'(IDLE_GAP - 1);
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          dout_q  <= 1'b0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign in_ready   = ready_q;
  assign Dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_fsm_frame_tx.sv
// tb_fsm_frame_tx: queue-based frame model checked every cycle, plus literal frame patterns.
module tb_fsm_frame_tx;
  localparam int W = 8;
  localparam int G = 2;
`ifdef FSM_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB     = 3 + W + P;
  localparam int PERIOD = NB + G + 1;
  localparam logic [31:0] E_A5 = P ? 32'hB4A : 32'h5A5;
  localparam logic [31:0] E_81 = P ? 32'hB02 : 32'h581;
  localparam logic [31:0] E_01 = P ? 32'hA03 : 32'h501;
  localparam logic [31:0] E_00 = P ? 32'hA00 : 32'h500;
  logic clk = 1'b0, Reset_n = 1'b1, in_valid = 1'b0;
  logic in_ready, Dout, busy, frame_done;
  logic [W-1:0] in_data = '0;
  int vecs = 0, miss = 0, cyc = 0, fd_total = 0;
  typedef struct packed {logic dout; logic busy; logic ready; logic fd;} exp_t;
  exp_t cur = '0;
  exp_t q[$];
  int rises[$];
  logic busy_prev = 1'b0;

  fsm_frame_tx #(.DATA_W(W), .IDLE_GAP(G)) dut (
    .clk(clk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .Dout(Dout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: a frame is a list of per-cycle expected outputs built at accept time
  initial forever begin
    @(posedge clk or negedge Reset_n);
    if (!Reset_n) begin
      q.delete();
      cur = '0;
    end else begin
      cyc++;
      if (q.size() == 0 && cur.ready && in_valid) begin
        for (int i = 0; i < NB; i++) begin
          logic b;
          if (i == 0 || i == 2) b = 1'b1;
          else if (i == 1) b = 1'b0;
          else if (i < 3 + W) b = in_data[W-1-(i-3)];
          else b = ^in_data;
          q.push_back(exp_t'{b, 1'b1, 1'b0, i == NB - 1});
        end
        repeat (G) q.push_back(exp_t'{1'b0, 1'b1, 1'b0, 1'b0});
      end
      cur = q.size() > 0 ? q.pop_front() : exp_t'{1'b0, 1'b0, 1'b1, 1'b0};
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cycle", 32'({Dout, busy, in_ready, frame_done}), 32'(cur));
    if (frame_done) fd_total++;
    if (busy && !busy_prev) rises.push_back(cyc);
    busy_prev = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic send_cap(input logic [W-1:0] d, input int n, output logic [31:0] bits,
                          output int fdpos, output int fdcnt);
    in_data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    chk("accept_wait", 32'(in_ready), 32'd1);
    bits = '0;
    fdpos = -1;
    fdcnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bits = {bits[30:0], Dout};
      if (frame_done) begin
        fdpos = k;
        fdcnt++;
      end
      if (k == 0) begin
        in_valid = 1'b0;
        in_data = ~d;
      end
    end
  endtask

  initial begin
    logic [31:0] bits;
    int fdpos, fdcnt, fd_before, dets, detpos;
    #1 Reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({Dout, busy, in_ready, frame_done}), 32'd0);
    #2 Reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("idle_outputs", 32'({Dout, busy, frame_done}), 32'd0);

    send_cap(8'hA5, NB + G, bits, fdpos, fdcnt);
    chk("a5_bits", bits, E_A5 << G);
    chk("a5_done_pos", 32'(fdpos), 32'(NB - 1));
    chk("a5_done_cnt", 32'(fdcnt), 32'd1);
    @(negedge clk);
    chk("a5_ready_back", 32'({in_ready, busy}), 32'b10);

    rises.delete();
    in_data = 8'h3C;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && rises.size() < 1; i++) @(negedge clk);
    in_data = 8'hC3;
    for (int i = 0; i < 50 && rises.size() < 2; i++) @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(rises.size()), 32'd2);
    if (rises.size() >= 2) chk("b2b_period", 32'(rises[1] - rises[0]), 32'(PERIOD));
    repeat (PERIOD + 1) @(negedge clk);

    fd_before = fd_total;
    in_data = 8'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("ff_bit4", 32'({Dout, busy}), 32'b11);
    #2 Reset_n = 1'b0;
    #1 chk("abort_outputs", 32'({Dout, busy, in_ready, frame_done}), 32'd0);
    @(negedge clk);
    #2 Reset_n = 1'b1;
    repeat (W) @(negedge clk);
    chk("abort_no_done", 32'(fd_total - fd_before), 32'd0);

    send_cap(8'h81, NB, bits, fdpos, fdcnt);
    chk("81_bits", bits, E_81);
    chk("81_done_pos", 32'(fdpos), 32'(NB - 1));
    repeat (G + 1) @(negedge clk);

    send_cap(8'h01, NB, bits, fdpos, fdcnt);
    chk("01_bits", bits, E_01);
    chk("01_done_cnt", 32'(fdcnt), 32'd1);
    repeat (G + 1) @(negedge clk);

    send_cap(8'h00, NB + G, bits, fdpos, fdcnt);
    chk("00_bits", bits, E_00 << G);
    dets = 0;
    detpos = -1;
    for (int k = 2; k < NB + G; k++) begin
      if (bits[NB+G-1-k] && bits[NB+G-1-(k-2)]) begin
        dets++;
        detpos = k;
      end
    end
    chk("det_count", 32'(dets), 32'd1);
    chk("det_pos", 32'(detpos), 32'd2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
